// File: rtl/fpnew_result_buffer_if.sv
// Result-beat handshake between the FPU output port, the result buffer and the core writeback port.
// Signal suffixes are named from the buffer's point of view.
interface fpnew_result_buffer_if #(
  parameter int unsigned Width    = 64,
  parameter int unsigned TagWidth = 1
);
  logic [Width-1:0]    in_result_i;
  logic [4:0]          in_status_i;
  logic [TagWidth-1:0] in_tag_i;
  logic                in_valid_i;
  logic                in_ready_o;

  logic [Width-1:0]    out_result_o;
  logic [4:0]          out_status_o;
  logic [TagWidth-1:0] out_tag_o;
  logic                out_valid_o;
  logic                out_ready_i;

  modport slave (
    input  in_result_i, in_status_i, in_tag_i, in_valid_i, out_ready_i,
    output in_ready_o, out_result_o, out_status_o, out_tag_o, out_valid_o
  );

  modport master (
    output in_result_i, in_status_i, in_tag_i, in_valid_i, out_ready_i,
    input  in_ready_o, out_result_o, out_status_o, out_tag_o, out_valid_o
  );
endinterface

// File: rtl/fpnew_result_buffer.sv
// In-order decoupling FIFO between the FPU output and core writeback, with sticky
// accumulation of the exception flags of every retired (popped, not flushed) result.
module fpnew_result_buffer #(
  parameter int unsigned Width    = 64,
  parameter int unsigned TagWidth = 1,
  parameter int unsigned Depth    = 4,
  localparam int unsigned CntWidth = $clog2(Depth) + 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic                fflags_clr_i,
  fpnew_result_buffer_if.slave io,
  output logic [4:0]          fflags_o,
  output logic [CntWidth-1:0] count_o,
  output logic                busy_o
);
  localparam int unsigned AddrWidth = $clog2(Depth);
  localparam logic [CntWidth-1:0] DepthCnt = CntWidth'(Depth);

  logic [Width-1:0]    result_q [Depth];
  logic [4:0]          status_q [Depth];
  logic [TagWidth-1:0] tag_q    [Depth];

  logic [AddrWidth-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrWidth-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntWidth-1:0]  count_q, count_d;
  logic [4:0]           fflags_q, fflags_d;

  logic push, pop, write_en;

  // Handshake outputs come from registered occupancy only, so the FPU never
  // sees a combinational path from the writeback ready.
  assign io.in_ready_o  = (count_q != DepthCnt);
  assign io.out_valid_o = (count_q != '0);

  assign io.out_result_o = result_q[rd_ptr_q];
  assign io.out_status_o = status_q[rd_ptr_q];
  assign io.out_tag_o    = tag_q[rd_ptr_q];

  assign push     = io.in_valid_i & io.in_ready_o;
  assign pop      = io.out_valid_o & io.out_ready_i;
  assign write_en = push & ~flush_i;

  assign fflags_o = fflags_q;
  assign count_o  = count_q;
  assign busy_o   = (count_q != '0);

  // Payload storage is not reset; out_valid_o masks stale contents.
  for (genvar gi = 0; gi < Depth; gi++) begin : g_entry
    always_ff @(posedge clk_i) begin
      if (write_en && (wr_ptr_q == AddrWidth'(gi))) begin
        result_q[gi] <= io.in_result_i;
        status_q[gi] <= io.in_status_i;
        tag_q[gi]    <= io.in_tag_i;
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    fflags_d = fflags_clr_i ? 5'b0 : fflags_q;

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AddrWidth'(1);
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AddrWidth'(1);
        // Clear takes effect first, then the retiring entry's flags are merged.
        fflags_d = fflags_d | io.out_status_o;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CntWidth'(1);
        2'b01:   count_d = count_q - CntWidth'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      fflags_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      fflags_q <= fflags_d;
    end
  end
endmodule

// File: tb/tb_fpnew_result_buffer.sv
// Directed and randomized checks of fpnew_result_buffer against a queue-based model.
module tb_fpnew_result_buffer;
  localparam int unsigned Width    = 32;
  localparam int unsigned TagWidth = 4;
  localparam int unsigned Depth    = 4;
  localparam int unsigned CntWidth = $clog2(Depth) + 1;

  typedef struct packed {
    logic [Width-1:0]    result;
    logic [4:0]          status;
    logic [TagWidth-1:0] tag;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  logic flush, fclr;
  logic [4:0] fflags;
  logic [CntWidth-1:0] count;
  logic busy;

  fpnew_result_buffer_if #(.Width(Width), .TagWidth(TagWidth)) bus_if ();

  fpnew_result_buffer #(.Width(Width), .TagWidth(TagWidth), .Depth(Depth)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .flush_i      (flush),
    .fflags_clr_i (fclr),
    .io           (bus_if),
    .fflags_o     (fflags),
    .count_o      (count),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  beat_t    q[$];
  logic [4:0] m_fflags = 5'b0;
  int errors = 0;
  int checks = 0;
  int pops   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [Width-1:0] res, input logic [4:0] st,
                       input logic [TagWidth-1:0] tg, input logic ordy);
    bus_if.in_valid_i  = v;
    bus_if.in_result_i = res;
    bus_if.in_status_i = st;
    bus_if.in_tag_i    = tg;
    bus_if.out_ready_i = ordy;
  endtask

  // Compare all visible state with the model, then advance one clock and update the model.
  task automatic cycle();
    beat_t head, nb;
    bit do_push, do_pop;
    int n;
    n = q.size();
    chk("count", 64'(count), 64'(n));
    chk("busy", 64'(busy), 64'(n != 0));
    chk("in_ready", 64'(bus_if.in_ready_o), 64'(n != Depth));
    chk("out_valid", 64'(bus_if.out_valid_o), 64'(n != 0));
    chk("fflags", 64'(fflags), 64'(m_fflags));
    head = '0;
    if (n != 0) begin
      head = q[0];
      chk("head_result", 64'(bus_if.out_result_o), 64'(head.result));
      chk("head_status", 64'(bus_if.out_status_o), 64'(head.status));
      chk("head_tag", 64'(bus_if.out_tag_o), 64'(head.tag));
    end
    nb      = '{result: bus_if.in_result_i, status: bus_if.in_status_i, tag: bus_if.in_tag_i};
    do_push = bus_if.in_valid_i && (n != Depth);
    do_pop  = bus_if.out_ready_i && (n != 0);
    @(posedge clk);
    #1;
    if (flush) q.delete();
    else begin
      if (do_pop) begin
        void'(q.pop_front());
        pops++;
        $display("pop tag=%0h result=%08h status=%05b", head.tag, head.result, head.status);
      end
      if (do_push) q.push_back(nb);
    end
    if (fclr) m_fflags = 5'b0;
    if (do_pop && !flush) m_fflags = m_fflags | head.status;
  endtask

  initial begin
    int p0;
    logic [4:0] saved;
    rst_n = 1'b0;
    flush = 1'b0;
    fclr  = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b0);
    #12;
    chk("rst_in_ready", 64'(bus_if.in_ready_o), 64'd1);
    chk("rst_out_valid", 64'(bus_if.out_valid_o), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_fflags", 64'(fflags), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    cycle();
    cycle();

    // Fill to full, hold a fifth beat, then drain in order.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, $urandom, 5'b0, TagWidth'(i), 1'b0);
      cycle();
    end
    chk("fill_count", 64'(count), 64'd4);
    chk("fill_in_ready", 64'(bus_if.in_ready_o), 64'd0);
    drive(1'b1, 32'hDEAD_BEEF, 5'b0, 4'hA, 1'b0);
    cycle();
    chk("fill_held_count", 64'(count), 64'd4);
    bus_if.out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("fill_order", 64'(bus_if.out_tag_o), 64'(i));
      cycle();
      if (i == 1) bus_if.in_valid_i = 1'b0;
    end
    chk("fill_fifth", 64'(bus_if.out_result_o), 64'h0000_0000_DEAD_BEEF);
    cycle();
    chk("fill_empty", 64'(count), 64'd0);

    // Streaming: one beat in and one out per cycle.
    p0 = pops;
    for (int i = 1; i <= 20; i++) begin
      drive(1'b1, Width'(i), 5'b0, TagWidth'(i), 1'b1);
      if (i > 1) chk("stream_head", 64'(bus_if.out_result_o), 64'(i - 1));
      cycle();
      chk("stream_count", 64'(count), 64'd1);
    end
    drive(1'b0, '0, '0, '0, 1'b1);
    chk("stream_last", 64'(bus_if.out_result_o), 64'd20);
    cycle();
    chk("stream_pops", 64'(pops - p0), 64'd20);

    // Sticky flags and clear-with-pop.
    drive(1'b0, '0, '0, '0, 1'b0);
    fclr = 1'b1;
    cycle();
    fclr = 1'b0;
    drive(1'b1, 32'h100, 5'b00001, 4'h1, 1'b0); cycle();
    drive(1'b1, 32'h101, 5'b00101, 4'h2, 1'b0); cycle();
    drive(1'b1, 32'h102, 5'b01000, 4'h3, 1'b0); cycle();
    drive(1'b0, '0, '0, '0, 1'b1);
    cycle();
    cycle();
    chk("fflags_acc", 64'(fflags), 64'b00101);
    fclr = 1'b1;
    cycle();
    fclr = 1'b0;
    chk("fflags_clr_pop", 64'(fflags), 64'b01000);

    // Flush with same-cycle push and pop.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, $urandom, 5'b10000, TagWidth'(i), 1'b0);
      cycle();
    end
    saved = fflags;
    drive(1'b1, 32'h5555_5555, 5'b10000, 4'hF, 1'b1);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b0);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(bus_if.out_valid_o), 64'd0);
    chk("flush_fflags", 64'(fflags), 64'(saved));
    cycle();

    // Asynchronous reset between edges with two entries held.
    drive(1'b1, 32'hA1, 5'b00010, 4'h1, 1'b0); cycle();
    drive(1'b1, 32'hA2, 5'b00010, 4'h2, 1'b0); cycle();
    drive(1'b0, '0, '0, '0, 1'b0);
    chk("pre_arst_count", 64'(count), 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(bus_if.out_valid_o), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_count", 64'(count), 64'd0);
    q.delete();
    m_fflags = 5'b0;
    cycle();
    rst_n = 1'b1;
    drive(1'b1, 32'hB0, 5'b0, 4'h7, 1'b0);
    cycle();
    drive(1'b0, '0, '0, '0, 1'b0);
    chk("post_arst_count", 64'(count), 64'd1);
    cycle();

    // Randomized traffic with occasional flush and flag clear.
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 3) != 0), $urandom, 5'($urandom), TagWidth'($urandom),
            1'($urandom_range(0, 2) != 0));
      flush = ($urandom_range(0, 31) == 0);
      fclr  = ($urandom_range(0, 15) == 0);
      cycle();
    end
    flush = 1'b0;
    fclr  = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b1);
    for (int i = 0; i < Depth + 1; i++) cycle();
    chk("final_empty", 64'(count), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
